dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared synchronous-read data memory.
- Requesters: the pipeline MEM stage (CPU port) and the debug/program-loader port (DBG port).
- Grants at most one access per cycle, using round-robin, with a bounded lock mode for DBG bursts. Drives the memory's word address, write data and byte-write enables, and returns read data one cycle later tagged to the owner.
- Sits between the MEM-stage lane/byte-enable logic and the data-memory macro. Produces the CPU stall when the CPU port loses arbitration.

---
 rtl/dm_arbiter_pkg.sv | 15 +
 rtl/dm_rr_pick.sv | 21 ++
 rtl/dm_arbiter.sv | 157 +++++++++++++++
 tb/tb_dm_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared state encoding, port identifiers and defaults for the data-memory arbiter.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int MAX_LOCK_DEFAULT = 16;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin selector: bit 0 is the CPU port, bit 1 the DBG port.
module dm_rr_pick
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester wins; on a tie the port that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DBG arbiter for the synchronous-read data memory with bounded DBG lock bursts
// and owner-tagged read return one cycle after the grant.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW       = 10,
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_be,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic [3:0]    dbg_be,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [3:0]    dm_wea,
    input  logic [31:0]   dm_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t    state_r, state_nxt_s;
    logic          last_gnt_r, last_nxt_s;
    logic [CW-1:0] lock_cnt_r, cnt_nxt_s, lock_inc_s;
    logic          rvalid_r, owner_r;
    logic          gnt_cpu_s, gnt_dbg_s;
    logic [1:0]    pick_s;
    logic          unused_s;

    assign unused_s   = ^{cpu_addr[31:AW+2], cpu_addr[1:0], dbg_addr[31:AW+2], dbg_addr[1:0]};
    assign lock_inc_s = lock_cnt_r + CW'(1);

    dm_rr_pick u_pick (
        .req  ({dbg_req, cpu_req}),
        .last (last_gnt_r),
        .gnt  (pick_s)
    );

    // Grant selection, next state, lock counter and round-robin history.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = lock_cnt_r;
        last_nxt_s  = last_gnt_r;
        gnt_cpu_s   = 1'b0;
        gnt_dbg_s   = 1'b0;
        case (state_r)
            ARB: begin
                gnt_cpu_s = pick_s[PORT_CPU];
                gnt_dbg_s = pick_s[PORT_DBG];
                if (gnt_dbg_s && dbg_lock) begin
                    state_nxt_s = (MAX_LOCK <= 1) ? FORCE : LOCK;
                    cnt_nxt_s   = CW'(1);
                end else begin
                    state_nxt_s = ARB;
                end
            end
            LOCK: begin
                gnt_dbg_s = dbg_req;
                // The grant that brings the count up to MAX_LOCK ends the window.
                if (dbg_req && dbg_lock) begin
                    cnt_nxt_s   = lock_inc_s;
                    state_nxt_s = (lock_inc_s >= CW'(MAX_LOCK)) ? FORCE : LOCK;
                end else begin
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ARB;
                end
            end
            FORCE: begin
                gnt_cpu_s = cpu_req;
                gnt_dbg_s = ~cpu_req & dbg_req;
                cnt_nxt_s = {CW{1'b0}};
                if (dbg_lock) begin
                    state_nxt_s = LOCK;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            default: begin
                cnt_nxt_s   = {CW{1'b0}};
                state_nxt_s = ARB;
            end
        endcase
        if (gnt_cpu_s) begin
            last_nxt_s = PORT_CPU;
        end else if (gnt_dbg_s || (state_r == LOCK)) begin
            last_nxt_s = PORT_DBG;
        end else begin
            last_nxt_s = last_gnt_r;
        end
    end

    assign cpu_gnt   = gnt_cpu_s & ~rst;
    assign dbg_gnt   = gnt_dbg_s & ~rst;
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    // Memory request mux for the granted port; idle cycles drive zeros.
    always_comb begin
        dm_addr  = {AW{1'b0}};
        dm_wdata = 32'h0000_0000;
        dm_wea   = 4'b0000;
        if (cpu_gnt) begin
            dm_addr  = cpu_addr[AW+1:2];
            dm_wdata = cpu_wdata;
            dm_wea   = cpu_we ? cpu_be : 4'b0000;
        end else if (dbg_gnt) begin
            dm_addr  = dbg_addr[AW+1:2];
            dm_wdata = dbg_wdata;
            dm_wea   = dbg_we ? dbg_be : 4'b0000;
        end else begin
            dm_addr  = {AW{1'b0}};
        end
    end

    // State, lock counter, round-robin history and read-return tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARB;
            last_gnt_r <= PORT_DBG;
            lock_cnt_r <= {CW{1'b0}};
            rvalid_r   <= 1'b0;
            owner_r    <= PORT_CPU;
        end else begin
            state_r    <= state_nxt_s;
            last_gnt_r <= last_nxt_s;
            lock_cnt_r <= cnt_nxt_s;
            rvalid_r   <= (gnt_cpu_s & ~cpu_we) | (gnt_dbg_s & ~dbg_we);
            if ((gnt_cpu_s & ~cpu_we) | (gnt_dbg_s & ~dbg_we)) begin
                owner_r <= gnt_dbg_s ? PORT_DBG : PORT_CPU;
            end else begin
                owner_r <= owner_r;
            end
        end
    end

    // A response still in flight when reset arrives is suppressed at once.
    assign cpu_rvalid = rvalid_r & (owner_r == PORT_CPU) & ~rst;
    assign dbg_rvalid = rvalid_r & (owner_r == PORT_DBG) & ~rst;
    assign cpu_rdata  = cpu_rvalid ? dm_rdata : 32'h0000_0000;
    assign dbg_rdata  = dbg_rvalid ? dm_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed per-cycle expectations plus a queue of
// expected read returns, checked by an independent negedge monitor.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]    cpu_be;
    logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]    dbg_be;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata, dm_rdata;
    logic [3:0]    dm_wea;

    logic [31:0] mem [0:(1<<AW)-1];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int cyc; logic cg; logic dg; logic st;
        logic [AW-1:0] a; logic [31:0] wd; logic [3:0] we;
    } cyc_exp_t;
    typedef struct { int cyc; logic port; logic [31:0] data; } rd_exp_t;

    cyc_exp_t cq[$];
    rd_exp_t  rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arbiter #(.AW(AW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wea(dm_wea), .dm_rdata(dm_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEAD_BEEF;
            8:       return 32'h1122_3344;
            default: return 32'h1000_0000 + 32'(i);
        endcase
    endfunction

    // Synchronous-read data memory with byte writes, reloaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (dm_wea[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
        dm_rdata <= mem[dm_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_be = 4'h0;
        dbg_lock = 1'b0;
    endtask

    task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    endtask

    task automatic dbg(input logic we, input logic lk, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
        dbg_req = 1'b1; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = wd; dbg_be = be;
    endtask

    task automatic expc(input logic cg, input logic dg, input logic st, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] we);
        cyc_exp_t e;
        e.cyc = cyc; e.cg = cg; e.dg = dg; e.st = st; e.a = a; e.wd = wd; e.we = we;
        cq.push_back(e);
    endtask

    task automatic expr(input logic port, input logic [31:0] d);
        rd_exp_t r;
        r.cyc = cyc + 1; r.port = port; r.data = d;
        rq.push_back(r);
    endtask

    // Monitor: compares the issue-side outputs and any read return against the queues.
    always @(negedge clk) begin : mon
        cyc_exp_t e;
        rd_exp_t  r;
        logic     ecv, edv;
        if (mon_en) begin
            if (cq.size() > 0) begin
                if (cq[0].cyc == cyc) begin
                    e = cq.pop_front();
                    chk("cpu_gnt",   32'(cpu_gnt),   32'(e.cg));
                    chk("dbg_gnt",   32'(dbg_gnt),   32'(e.dg));
                    chk("cpu_stall", 32'(cpu_stall), 32'(e.st));
                    chk("dm_addr",   32'(dm_addr),   32'(e.a));
                    chk("dm_wdata",  dm_wdata,       e.wd);
                    chk("dm_wea",    32'(dm_wea),    32'(e.we));
                end
            end
            ecv = 1'b0;
            edv = 1'b0;
            if (rq.size() > 0) begin
                if (rq[0].cyc == cyc) begin
                    ecv = (rq[0].port == PORT_CPU);
                    edv = (rq[0].port == PORT_DBG);
                end
            end
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(edv));
            if (ecv || edv) begin
                r = rq.pop_front();
                if (ecv) chk("cpu_rdata", cpu_rdata, r.data);
                else     chk("dbg_rdata", dbg_rdata, r.data);
            end
            if (!ecv) chk("cpu_rdata_idle", cpu_rdata, 32'h0);
            if (!edv) chk("dbg_rdata_idle", dbg_rdata, 32'h0);
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        // Reset cycle with a CPU request present: nothing may be granted.
        tick(); mon_en = 1'b1; idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0);
        expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        // Simultaneous writes: CPU wins the first tie, then DBG.
        tick(); rst = 1'b0; idle();
        cpu(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011); dbg(1'b1, 1'b0, 32'h24, 32'h5566_7788, 4'b1111);
        expc(1'b1, 1'b0, 1'b0, 10'd8, 32'hAABB_CCDD, 4'b0011);
        tick(); idle(); dbg(1'b1, 1'b0, 32'h24, 32'h5566_7788, 4'b1111);
        expc(1'b0, 1'b1, 1'b0, 10'd9, 32'h5566_7788, 4'b1111);
        // Dual read requests alternate grants.
        tick(); idle(); cpu(1'b0, 32'h20, 32'h0, 4'h0); dbg(1'b0, 1'b0, 32'h24, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd8, 32'h0, 4'h0); expr(PORT_CPU, 32'h1122_CCDD);
        tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0); dbg(1'b0, 1'b0, 32'h24, 32'h0, 4'h0);
        expc(1'b0, 1'b1, 1'b1, 10'd9, 32'h0, 4'h0); expr(PORT_DBG, 32'h5566_7788);
        tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0); dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd4, 32'h0, 4'h0); expr(PORT_CPU, 32'hDEAD_BEEF);
        tick(); idle(); dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expc(1'b0, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0); expr(PORT_DBG, 32'h1000_0000);
        // Lone CPU read of word 4.
        tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd4, 32'h0, 4'h0); expr(PORT_CPU, 32'hDEAD_BEEF);
        tick(); idle(); expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        // Pipelined CPU reads of words 0, 1, 2.
        for (int k = 0; k < 3; k++) begin
            tick(); idle(); cpu(1'b0, 32'(4 * k), 32'h0, 4'h0);
            expc(1'b1, 1'b0, 1'b0, 10'(k), 32'h0, 4'h0); expr(PORT_CPU, 32'h1000_0000 + 32'(k));
        end
        // Write with no byte enables is granted but leaves memory unchanged.
        tick(); idle(); cpu(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000);
        expc(1'b1, 1'b0, 1'b0, 10'd12, 32'hFFFF_FFFF, 4'b0000);
        tick(); idle(); cpu(1'b0, 32'h30, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd12, 32'h0, 4'h0); expr(PORT_CPU, 32'h1000_000C);
        // Lock burst: four DBG grants while the CPU stalls, one forced CPU slot, DBG resumes.
        for (int k = 0; k < 4; k++) begin
            tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0); dbg(1'b0, 1'b1, 32'h40 + 32'(4 * k), 32'h0, 4'h0);
            expc(1'b0, 1'b1, 1'b1, 10'(16 + k), 32'h0, 4'h0); expr(PORT_DBG, 32'h1000_0010 + 32'(k));
        end
        tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0); dbg(1'b0, 1'b1, 32'h50, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd4, 32'h0, 4'h0); expr(PORT_CPU, 32'hDEAD_BEEF);
        tick(); idle(); cpu(1'b0, 32'h14, 32'h0, 4'h0); dbg(1'b0, 1'b1, 32'h50, 32'h0, 4'h0);
        expc(1'b0, 1'b1, 1'b1, 10'd20, 32'h0, 4'h0); expr(PORT_DBG, 32'h1000_0014);
        tick(); idle(); cpu(1'b0, 32'h14, 32'h0, 4'h0);
        expc(1'b0, 1'b0, 1'b1, 10'd0, 32'h0, 4'h0);
        tick(); idle(); cpu(1'b0, 32'h14, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd5, 32'h0, 4'h0); expr(PORT_CPU, 32'h1000_0005);
        // Lock release after two DBG grants hands the next slot to the waiting CPU.
        for (int k = 0; k < 2; k++) begin
            tick(); idle(); cpu(1'b0, 32'h18, 32'h0, 4'h0); dbg(1'b0, 1'b1, 32'h60 + 32'(4 * k), 32'h0, 4'h0);
            expc(1'b0, 1'b1, 1'b1, 10'(24 + k), 32'h0, 4'h0); expr(PORT_DBG, 32'h1000_0018 + 32'(k));
        end
        tick(); idle(); cpu(1'b0, 32'h18, 32'h0, 4'h0);
        expc(1'b0, 1'b0, 1'b1, 10'd0, 32'h0, 4'h0);
        tick(); idle(); cpu(1'b0, 32'h18, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd6, 32'h0, 4'h0); expr(PORT_CPU, 32'h1000_0006);
        // Reset right after a DBG read grant: its response must never appear.
        tick(); idle(); dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expc(1'b0, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0);
        tick(); idle(); rst = 1'b1; expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        tick(); idle(); rst = 1'b0; expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        // Tie after reset goes to the CPU again.
        tick(); idle(); cpu(1'b0, 32'h10, 32'h0, 4'h0); dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expc(1'b1, 1'b0, 1'b0, 10'd4, 32'h0, 4'h0); expr(PORT_CPU, 32'hDEAD_BEEF);
        tick(); idle(); dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expc(1'b0, 1'b1, 1'b0, 10'd0, 32'h0, 4'h0); expr(PORT_DBG, 32'h1000_0000);
        tick(); idle(); expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        tick(); idle(); expc(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        tick();
        chk("issue_queue_drained", 32'(cq.size()), 32'h0);
        chk("read_queue_drained",  32'(rq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
